// File: rtl/axi_mem_responder_pkg.sv
// Shared codes, state encodings and width helpers for the AXI4 memory responder.
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam int BYTE_BITS          = 8;
    localparam int DATA_WIDTH_DEFAULT = 512;
    localparam int OFFSET_BITS        = $clog2(DATA_WIDTH_DEFAULT / BYTE_BITS);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_e;

    // Byte-offset bits for an arbitrary data width (OFFSET_BITS covers the default).
    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / BYTE_BITS);
    endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, 1-cycle registered read port.
module axi_mem_responder_ram
    import axi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_BITS  = 12
) (
    input  logic                             clk,
    input  logic                             i_we,
    input  logic [ADDR_BITS-1:0]             i_waddr,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    input  logic [DATA_WIDTH/BYTE_BITS-1:0]  i_wstrb,
    input  logic                             i_re,
    input  logic [ADDR_BITS-1:0]             i_raddr,
    output logic [DATA_WIDTH-1:0]            o_rdata
);
    localparam int STRB_W = DATA_WIDTH / BYTE_BITS;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read samples before the write lands, so a same-cycle collision returns old data.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*BYTE_BITS +: BYTE_BITS] <= i_wdata[b*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backing an on-chip RAM; independent read/write FSMs, one burst in flight per direction.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 512,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    ID_WIDTH       = 32,
    parameter int                    MEM_WORDS_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axi_mem_awvalid,
    output logic                    s_axi_mem_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_mem_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_mem_awid,
    input  logic [7:0]              s_axi_mem_awlen,
    input  logic [1:0]              s_axi_mem_awburst,
    input  logic                    s_axi_mem_wvalid,
    output logic                    s_axi_mem_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_mem_wstrb,
    input  logic                    s_axi_mem_wlast,
    output logic                    s_axi_mem_bvalid,
    input  logic                    s_axi_mem_bready,
    output logic [ID_WIDTH-1:0]     s_axi_mem_bid,
    output logic [1:0]              s_axi_mem_bresp,
    input  logic                    s_axi_mem_arvalid,
    output logic                    s_axi_mem_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_mem_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_mem_arid,
    input  logic [7:0]              s_axi_mem_arlen,
    input  logic [1:0]              s_axi_mem_arburst,
    output logic                    s_axi_mem_rvalid,
    input  logic                    s_axi_mem_rready,
    output logic [ID_WIDTH-1:0]     s_axi_mem_rid,
    output logic [1:0]              s_axi_mem_rresp,
    output logic [DATA_WIDTH-1:0]   s_axi_mem_rdata,
    output logic                    s_axi_mem_rlast
);
    localparam int OFF_BITS = offset_bits(DATA_WIDTH);
    localparam int WORD_W   = ADDR_WIDTH - OFF_BITS;

    // ---------------- write channel ----------------
    w_state_e                r_w_state;
    logic                    r_awready, r_wready, r_bvalid;
    logic [ID_WIDTH-1:0]     r_bid, r_aw_id;
    logic [1:0]              r_bresp;
    logic [WORD_W-1:0]       r_aw_word;
    logic                    r_aw_under, r_aw_fixed, r_w_err;
    logic [7:0]              r_aw_len, r_w_beat;

    logic [ADDR_WIDTH-1:0]   w_aw_diff;
    logic                    w_aw_borrow;
    logic                    w_aw_inrange, w_w_hs, w_w_last_beat, w_w_beat_err, w_ram_we;

    // The borrow out of (addr - BASE_ADDR) flags addresses below the window.
    assign {w_aw_borrow, w_aw_diff} = {1'b0, s_axi_mem_awaddr} - {1'b0, BASE_ADDR};
    assign w_aw_inrange  = !r_aw_under && ((r_aw_word >> MEM_WORDS_LOG2) == '0);
    assign w_w_hs        = r_wready && s_axi_mem_wvalid;
    assign w_w_last_beat = (r_w_beat == r_aw_len);
    assign w_w_beat_err  = !w_aw_inrange || (s_axi_mem_wlast != w_w_last_beat);
    assign w_ram_we      = w_w_hs && w_aw_inrange;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_state  <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
            r_aw_id    <= '0;
            r_aw_word  <= '0;
            r_aw_under <= 1'b0;
            r_aw_fixed <= 1'b0;
            r_aw_len   <= '0;
            r_w_beat   <= '0;
            r_w_err    <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && s_axi_mem_awvalid) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_aw_id    <= s_axi_mem_awid;
                        r_aw_word  <= WORD_W'(w_aw_diff >> OFF_BITS);
                        r_aw_under <= w_aw_borrow;
                        r_aw_len   <= s_axi_mem_awlen;
                        r_aw_fixed <= (s_axi_mem_awburst == BURST_FIXED);
                        r_w_beat   <= '0;
                        r_w_err    <= 1'b0;
                        r_w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (w_w_last_beat) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bid     <= r_aw_id;
                            r_bresp   <= (r_w_err || w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_w_state <= W_RESP;
                        end else begin
                            r_w_beat <= r_w_beat + 8'd1;
                            r_w_err  <= r_w_err || w_w_beat_err;
                            if (!r_aw_fixed) begin
                                r_aw_word <= r_aw_word + WORD_W'(1);
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_mem_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_e                r_r_state;
    logic                    r_arready, r_rvalid, r_rlast, r_rd_err;
    logic [ID_WIDTH-1:0]     r_rid, r_ar_id;
    logic [1:0]              r_rresp;
    logic [WORD_W-1:0]       r_ar_word;
    logic                    r_ar_under, r_ar_fixed;
    logic [7:0]              r_ar_len, r_r_beat;

    logic [ADDR_WIDTH-1:0]   w_ar_diff;
    logic                    w_ar_borrow;
    logic                    w_ar_inrange, w_ram_re;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;

    assign {w_ar_borrow, w_ar_diff} = {1'b0, s_axi_mem_araddr} - {1'b0, BASE_ADDR};
    assign w_ar_inrange = !r_ar_under && ((r_ar_word >> MEM_WORDS_LOG2) == '0);
    assign w_ram_re     = (r_r_state == R_FETCH) && w_ar_inrange;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r_state  <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rid      <= '0;
            r_rresp    <= RESP_OKAY;
            r_ar_id    <= '0;
            r_ar_word  <= '0;
            r_ar_under <= 1'b0;
            r_ar_fixed <= 1'b0;
            r_ar_len   <= '0;
            r_r_beat   <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && s_axi_mem_arvalid) begin
                        r_arready  <= 1'b0;
                        r_ar_id    <= s_axi_mem_arid;
                        r_ar_word  <= WORD_W'(w_ar_diff >> OFF_BITS);
                        r_ar_under <= w_ar_borrow;
                        r_ar_len   <= s_axi_mem_arlen;
                        r_ar_fixed <= (s_axi_mem_arburst == BURST_FIXED);
                        r_r_beat   <= '0;
                        r_r_state  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_rvalid  <= 1'b1;
                    r_rlast   <= (r_r_beat == r_ar_len);
                    r_rid     <= r_ar_id;
                    r_rresp   <= w_ar_inrange ? RESP_OKAY : RESP_SLVERR;
                    r_rd_err  <= !w_ar_inrange;
                    r_r_state <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_mem_rready) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_r_beat  <= r_r_beat + 8'd1;
                            r_r_state <= R_FETCH;
                            if (!r_ar_fixed) begin
                                r_ar_word <= r_ar_word + WORD_W'(1);
                            end
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    axi_mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_WORDS_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_aw_word[MEM_WORDS_LOG2-1:0]),
        .i_wdata (s_axi_mem_wdata),
        .i_wstrb (s_axi_mem_wstrb),
        .i_re    (w_ram_re),
        .i_raddr (r_ar_word[MEM_WORDS_LOG2-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign s_axi_mem_awready = r_awready;
    assign s_axi_mem_wready  = r_wready;
    assign s_axi_mem_bvalid  = r_bvalid;
    assign s_axi_mem_bid     = r_bid;
    assign s_axi_mem_bresp   = r_bresp;
    assign s_axi_mem_arready = r_arready;
    assign s_axi_mem_rvalid  = r_rvalid;
    assign s_axi_mem_rid     = r_rid;
    assign s_axi_mem_rresp   = r_rresp;
    assign s_axi_mem_rlast   = r_rlast;
    // RAM output register is never reset, so rdata is forced to zero unless a good beat is presented.
    assign s_axi_mem_rdata   = (r_rvalid && !r_rd_err) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed table, corner sequences and random bursts against a word-array model.
module tb_axi_mem_responder;
    localparam int DW     = 64;
    localparam int AW     = 32;
    localparam int IW     = 8;
    localparam int MWL    = 6;
    localparam int DEPTH  = 64;
    localparam int BUDGET = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [7:0]    awlen, arlen;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [7:0]    wstrb;

    axi_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS_LOG2(MWL), .BASE_ADDR('0)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_mem_awvalid(awvalid), .s_axi_mem_awready(awready), .s_axi_mem_awaddr(awaddr),
        .s_axi_mem_awid(awid), .s_axi_mem_awlen(awlen), .s_axi_mem_awburst(awburst),
        .s_axi_mem_wvalid(wvalid), .s_axi_mem_wready(wready), .s_axi_mem_wdata(wdata),
        .s_axi_mem_wstrb(wstrb), .s_axi_mem_wlast(wlast),
        .s_axi_mem_bvalid(bvalid), .s_axi_mem_bready(bready), .s_axi_mem_bid(bid), .s_axi_mem_bresp(bresp),
        .s_axi_mem_arvalid(arvalid), .s_axi_mem_arready(arready), .s_axi_mem_araddr(araddr),
        .s_axi_mem_arid(arid), .s_axi_mem_arlen(arlen), .s_axi_mem_arburst(arburst),
        .s_axi_mem_rvalid(rvalid), .s_axi_mem_rready(rready), .s_axi_mem_rid(rid),
        .s_axi_mem_rresp(rresp), .s_axi_mem_rdata(rdata), .s_axi_mem_rlast(rlast)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] beat_data [256];
    logic [7:0]    beat_strb [256];
    time aw_hs_t, ar_hs_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  id;
        int          len;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] dseed;
        bit          bad_last;
        int          stall;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word index of beat k: FIXED holds the start word, anything else counts up.
    function automatic logic [28:0] beat_word(input logic [31:0] addr, input int k, input logic [1:0] burst);
        logic [28:0] w0;
        w0 = addr[31:3];
        return (burst == 2'b00) ? w0 : w0 + 29'(k);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input int len,
                            input logic [1:0] burst, input bit bad_last, input int bstall,
                            output logic [1:0] resp);
        int t;
        bit err;
        logic [28:0] w;
        logic [1:0] b_resp;
        logic [7:0] b_id;
        err = bad_last;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = 8'(len); awburst = burst;
        t = 0;
        while (!awready && t < BUDGET) begin @(negedge clk); t++; end
        check("aw_timeout", 64'(t >= BUDGET), 64'd0);
        aw_hs_t = $time;
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wvalid = 1'b1; wdata = beat_data[k]; wstrb = beat_strb[k];
            wlast = bad_last ? (k != len) : (k == len);
            t = 0;
            while (!wready && t < BUDGET) begin @(negedge clk); t++; end
            check("w_timeout", 64'(t >= BUDGET), 64'd0);
            w = beat_word(addr, k, burst);
            if (w < 29'(DEPTH)) begin
                for (int b = 0; b < 8; b++)
                    if (beat_strb[k][b]) model_mem[w[5:0]][b*8 +: 8] = beat_data[k][b*8 +: 8];
            end else begin
                err = 1'b1;
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < BUDGET) begin @(negedge clk); t++; end
        check("b_timeout", 64'(t >= BUDGET), 64'd0);
        b_resp = bresp; b_id = bid;
        check("bid", 64'(bid), 64'(id));
        check("bresp", 64'(bresp), err ? 64'd2 : 64'd0);
        for (int i = 0; i < bstall; i++) begin
            @(negedge clk);
            check("b_hold", 64'({bvalid, bid, bresp}), 64'({1'b1, b_id, b_resp}));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_drop", 64'(bvalid), 64'd0);
        check("aw_rearm", 64'(awready), 64'd1);
        resp = b_resp;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input int len,
                           input logic [1:0] burst, input int rstall, output logic [1:0] agg);
        int t;
        logic [28:0] w;
        logic [63:0] exp_d, h_d;
        logic [11:0] h_ctl;
        agg = 2'b00;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = 8'(len); arburst = burst;
        t = 0;
        while (!arready && t < BUDGET) begin @(negedge clk); t++; end
        check("ar_timeout", 64'(t >= BUDGET), 64'd0);
        ar_hs_t = $time;
        @(negedge clk);
        arvalid = 1'b0;
        check("r_lat1", 64'(rvalid), 64'd0);
        for (int k = 0; k <= len; k++) begin
            t = 0;
            while (!rvalid && t < BUDGET) begin @(negedge clk); t++; end
            check("r_gap", 64'(t), 64'd1);
            w = beat_word(addr, k, burst);
            exp_d = (w < 29'(DEPTH)) ? model_mem[w[5:0]] : 64'd0;
            check("rdata", rdata, exp_d);
            check("rresp", 64'(rresp), (w < 29'(DEPTH)) ? 64'd0 : 64'd2);
            check("rlast", 64'(rlast), 64'(k == len));
            check("rid", 64'(rid), 64'(id));
            agg = agg | rresp;
            h_d = rdata; h_ctl = {rvalid, rlast, rresp, rid};
            for (int i = 0; i < rstall; i++) begin
                @(negedge clk);
                check("r_hold_data", rdata, h_d);
                check("r_hold_ctl", 64'({rvalid, rlast, rresp, rid}), 64'(h_ctl));
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check("ar_rearm", 64'(arready), 64'd1);
    endtask

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp, resp2;
        logic [31:0] a;
        int len;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;

        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_payload", 64'({rlast, bresp, rresp, bid, rid}), 64'd0);
        check("rst_rdata",   rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("awready_after_release", 64'(awready), 64'd0);
        @(negedge clk);
        check("awready_rise", 64'(awready), 64'd1);
        check("arready_rise", 64'(arready), 64'd1);

        // Give every RAM word a known value so the model is complete.
        for (int k = 0; k < DEPTH; k++) begin beat_data[k] = {$urandom, $urandom}; beat_strb[k] = 8'hFF; end
        do_write(32'h0, 8'h00, DEPTH - 1, 2'b01, 1'b0, 0, resp);

        tbl[0]  = '{1, 32'h040, 8'd5,  0, 2'b01, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0, 0, 2'b00};
        tbl[1]  = '{0, 32'h040, 8'd5,  0, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[2]  = '{1, 32'h000, 8'd1,  3, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[3]  = '{0, 32'h000, 8'd2,  3, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[4]  = '{1, 32'h100, 8'd3,  0, 2'b01, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 2'b00};
        tbl[5]  = '{1, 32'h100, 8'd3,  0, 2'b01, 8'h01, 64'h0,                0, 0, 2'b00};
        tbl[6]  = '{0, 32'h100, 8'd4,  0, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[7]  = '{0, 32'h200, 8'd6,  0, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b10};
        tbl[8]  = '{1, 32'h200, 8'd7,  0, 2'b01, 8'hFF, 64'h1234,             0, 0, 2'b10};
        tbl[9]  = '{0, 32'h000, 8'd8,  0, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[10] = '{1, 32'h050, 8'd9,  3, 2'b00, 8'hFF, 64'h100,              0, 0, 2'b00};
        tbl[11] = '{0, 32'h050, 8'd10, 2, 2'b00, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[12] = '{0, 32'h1F0, 8'd11, 3, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b10};
        tbl[13] = '{1, 32'h060, 8'd12, 2, 2'b01, 8'hFF, 64'h5000,             1, 0, 2'b10};
        tbl[14] = '{0, 32'h060, 8'd13, 2, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};
        tbl[15] = '{1, 32'h070, 8'd14, 1, 2'b11, 8'hFF, 64'h7000,             0, 5, 2'b00};
        tbl[16] = '{0, 32'h070, 8'd15, 1, 2'b10, 8'hFF, 64'h0,                0, 5, 2'b00};
        tbl[17] = '{1, 32'h1F8, 8'd16, 1, 2'b01, 8'hFF, 64'h9000,             0, 0, 2'b10};
        tbl[18] = '{0, 32'h1F8, 8'd17, 0, 2'b01, 8'hFF, 64'h0,                0, 0, 2'b00};

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_wr) begin
                for (int k = 0; k <= tbl[i].len; k++) begin
                    beat_data[k] = tbl[i].dseed + 64'(k);
                    beat_strb[k] = tbl[i].strb;
                end
                do_write(tbl[i].addr, tbl[i].id, tbl[i].len, tbl[i].burst, tbl[i].bad_last, tbl[i].stall, resp);
            end else begin
                do_read(tbl[i].addr, tbl[i].id, tbl[i].len, tbl[i].burst, tbl[i].stall, resp);
            end
            check($sformatf("tbl%0d_resp", i), 64'(resp), 64'(tbl[i].exp_resp));
        end
        // Byte 0 cleared by the strobed write, the rest still 0xFF.
        check("partial_strobe_model", model_mem[32], 64'hFFFFFFFFFFFFFF00);

        beat_data[0] = 64'hC0FFEE0012345678; beat_strb[0] = 8'hFF;
        fork
            do_write(32'h020, 8'h21, 0, 2'b01, 1'b0, 0, resp);
            do_read(32'h180, 8'h22, 0, 2'b01, 0, resp2);
        join
        check("concurrent_accept", 64'(ar_hs_t), 64'(aw_hs_t));
        check("concurrent_bresp", 64'(resp), 64'd0);

        for (int it = 0; it < 40; it++) begin
            a = 32'($urandom_range(0, 70) * 8 + $urandom_range(0, 7));
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= len; k++) begin
                    beat_data[k] = {$urandom, $urandom};
                    beat_strb[k] = 8'($urandom_range(0, 255));
                end
                do_write(a, 8'($urandom_range(0, 255)), len, 2'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0), $urandom_range(0, 3), resp);
            end else begin
                do_read(a, 8'($urandom_range(0, 255)), len, 2'($urandom_range(0, 3)),
                        $urandom_range(0, 3), resp);
            end
        end

        // Reset in the middle of a len=7 write: beats 0 and 1 land, beat 2 never does.
        for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
        awvalid = 1'b1; awaddr = 32'h080; awid = 8'h33; awlen = 8'd7; awburst = 2'b01;
        begin
            int t;
            t = 0;
            while (!awready && t < BUDGET) begin @(negedge clk); t++; end
            check("rst_aw_timeout", 64'(t >= BUDGET), 64'd0);
            @(negedge clk);
            awvalid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                wvalid = 1'b1; wdata = beat_data[k]; wstrb = 8'hFF; wlast = 1'b0;
                t = 0;
                while (!wready && t < BUDGET) begin @(negedge clk); t++; end
                check("rst_w_timeout", 64'(t >= BUDGET), 64'd0);
                model_mem[16 + k] = beat_data[k];
                @(negedge clk);
            end
        end
        wvalid = 1'b1; wdata = beat_data[2];
        #2 reset = 1'b1;
        #1;
        check("midrst_awready", 64'(awready), 64'd0);
        check("midrst_wready",  64'(wready),  64'd0);
        check("midrst_bvalid",  64'(bvalid),  64'd0);
        check("midrst_arready", 64'(arready), 64'd0);
        check("midrst_rvalid",  64'(rvalid),  64'd0);
        @(negedge clk);
        wvalid = 1'b0;
        reset = 1'b0;
        #1 check("midrst_awready_hold", 64'(awready), 64'd0);
        @(negedge clk);
        check("midrst_awready_rise", 64'(awready), 64'd1);
        check("midrst_no_bvalid", 64'(bvalid), 64'd0);
        do_read(32'h080, 8'h34, 7, 2'b01, 0, resp);
        check("midrst_read_resp", 64'(resp), 64'd0);
        beat_data[0] = 64'h0123456789ABCDEF; beat_strb[0] = 8'hFF;
        do_write(32'h088, 8'h35, 0, 2'b01, 1'b0, 0, resp);
        check("midrst_write_resp", 64'(resp), 64'd0);
        do_read(32'h088, 8'h36, 0, 2'b01, 0, resp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
